// File: rtl/axi_lite_req_master_if.sv
// AXI4-Lite channel bundle between a single-request master and its slave.
interface axi_lite_req_master_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_req_master.sv
// Single-request to AXI4-Lite master: one outstanding write or read, response on valid/ready.
// Optional abort timer enabled by defining AXI_LITE_REQ_TIMEOUT_EN.
module axi_lite_req_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  axi_lite_req_master_if.master m_axi
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t              state, state_d;
  logic                aw_done, aw_done_d, w_done, w_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                req_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                accept_c, aw_fin_c, w_fin_c, tmo_hit_c;

  assign accept_c = (state == IDLE) && req_valid_i && req_ready_o;
  assign aw_fin_c = aw_done || (m_axi.awvalid && m_axi.awready);
  assign w_fin_c  = w_done  || (m_axi.wvalid  && m_axi.wready);

  assign m_axi.awaddr = addr_q;
  assign m_axi.araddr = addr_q;
  assign m_axi.wdata  = 32'(wdata_q);
  assign m_axi.wstrb  = 4'(wstrb_q);
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

`ifdef AXI_LITE_REQ_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             busy_c;

  assign busy_c    = state inside {WR_AW_W, WR_B, RD_AR, RD_R};
  assign tmo_hit_c = busy_c && (tmo_cnt == CNT_LAST);

  // Saturating wait counter, restarted by every accepted request
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      tmo_cnt <= '0;
    end else if (accept_c) begin
      tmo_cnt <= '0;
    end else if (busy_c && (tmo_cnt != CNT_MAX)) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
  assign tmo_hit_c  = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d     = state;
    aw_done_d   = aw_done;
    w_done_d    = w_done;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    bready_d    = 1'b0;
    arvalid_d   = 1'b0;
    rready_d    = 1'b0;
    rsp_valid_d = rsp_valid_o;
    rsp_rdata_d = rsp_rdata_o;
    rsp_err_d   = rsp_err_o;

    case (state)
      IDLE: begin
        if (accept_c) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_we_i) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        aw_done_d = aw_fin_c;
        w_done_d  = w_fin_c;
        awvalid_d = !aw_fin_c;
        wvalid_d  = !w_fin_c;
        if (aw_fin_c && w_fin_c) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        bready_d = 1'b1;
        if (m_axi.bvalid && m_axi.bready) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = (m_axi.bresp != 2'b00);
          state_d     = RSP;
        end
      end
      RD_AR: begin
        arvalid_d = 1'b1;
        if (m_axi.arvalid && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        rready_d = 1'b1;
        if (m_axi.rvalid && m_axi.rready) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = DATA_W'(m_axi.rdata);
          rsp_err_d   = (m_axi.rresp != 2'b00);
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abandon the bus transaction and report an error
    if (tmo_hit_c) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
      state_d     = RSP;
    end

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
    end else begin
      state         <= state_d;
      aw_done       <= aw_done_d;
      w_done        <= w_done_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      m_axi.awvalid <= awvalid_d;
      m_axi.wvalid  <= wvalid_d;
      m_axi.bready  <= bready_d;
      m_axi.arvalid <= arvalid_d;
      m_axi.rready  <= rready_d;
      req_ready_o   <= req_ready_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_rdata_o   <= rsp_rdata_d;
      rsp_err_o     <= rsp_err_d;
    end
  end

endmodule
